// File: rtl/autosym_eval_pipe.sv
// Two-stage streaming evaluator for f(x) = g(A*x (+c)): GF(2) projection, then truth-table lookup.
// Define AUTOSYM_AFFINE_EN to add the offset vector c (cfg_sel = 2); otherwise the projection is purely linear.
module autosym_eval_pipe #(
  parameter int N_IN  = 10,
  parameter int K_RED = 4,
  parameter int N_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [K_RED-1:0]   cfg_addr,
  input  logic [N_IN-1:0]    cfg_wdata,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_y,
  output logic [K_RED-1:0]   out_z
);

  localparam int TBL_DEPTH = 1 << K_RED;
  localparam int ROW_AW    = (K_RED > 1) ? $clog2(K_RED) : 1;

  logic [N_IN-1:0]  row_r [K_RED];
  logic [N_OUT-1:0] tbl_r [TBL_DEPTH];
  logic [K_RED-1:0] off_s;
  logic [K_RED-1:0] z_s;
  logic [K_RED-1:0] s1_z_r;
  logic             s1_v_r;
  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             cfg_take_s;
  logic             in_take_s;
  logic             row_addr_ok_s;

  function automatic logic parity_f(input logic [N_IN-1:0] v);
    parity_f = ^v;
  endfunction

`ifdef AUTOSYM_AFFINE_EN
  logic [K_RED-1:0] off_r;
  assign off_s = off_r;
`else
  assign off_s = {K_RED{1'b0}};
`endif

  // Handshake: config only when the pipeline is empty, and it beats a simultaneous input.
  assign s2_adv_s      = !out_valid || out_ready;
  assign s1_adv_s      = !s1_v_r || s2_adv_s;
  assign cfg_ready     = !rst && !s1_v_r && !out_valid;
  assign cfg_take_s    = cfg_we && cfg_ready;
  assign in_ready      = !rst && s1_adv_s && !cfg_take_s;
  assign in_take_s     = in_valid && in_ready;
  assign row_addr_ok_s = ({{(32-K_RED){1'b0}}, cfg_addr} < 32'(K_RED));

  // Stage-1 projection: each z bit is the parity of its row mask applied to x.
  always_comb begin
    z_s = {K_RED{1'b0}};
    for (int i = 0; i < K_RED; i++) begin
      z_s[i] = parity_f(row_r[i] & in_x) ^ off_s[i];
    end
  end

  // Configuration storage: identity matrix and zero table out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K_RED; i++) begin
        row_r[i] <= {{(N_IN-1){1'b0}}, 1'b1} << i;
      end
      for (int j = 0; j < TBL_DEPTH; j++) begin
        tbl_r[j] <= {N_OUT{1'b0}};
      end
`ifdef AUTOSYM_AFFINE_EN
      off_r <= {K_RED{1'b0}};
`endif
    end else if (cfg_take_s) begin
      case (cfg_sel)
        2'd0: begin
          if (row_addr_ok_s) begin
            row_r[cfg_addr[ROW_AW-1:0]] <= cfg_wdata;
          end
        end
        2'd1: tbl_r[cfg_addr] <= cfg_wdata[N_OUT-1:0];
        2'd2: begin
`ifdef AUTOSYM_AFFINE_EN
          off_r <= cfg_wdata[K_RED-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  // Pipeline registers; S2 holds its result while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s1_z_r    <= {K_RED{1'b0}};
      out_valid <= 1'b0;
      out_y     <= {N_OUT{1'b0}};
      out_z     <= {K_RED{1'b0}};
    end else begin
      if (s1_adv_s) begin
        s1_v_r <= in_take_s;
        if (in_take_s) begin
          s1_z_r <= z_s;
        end
      end
      if (s2_adv_s) begin
        out_valid <= s1_v_r;
        if (s1_v_r) begin
          out_y <= tbl_r[s1_z_r];
          out_z <= s1_z_r;
        end
      end
    end
  end

endmodule
